// File: rtl/ppi_ctrl.sv
// ppi_ctrl: 8255-style bus controller.
// Decodes CPU reads and writes into the port A/B/C latches, the control word and
// port C bit set/reset. It runs Mode 0 on both groups and the Mode 1 strobed
// handshake on group A. Pin-level signals are split into in/out/oe so that the
// PPI top level can build its bidirectional pads.
module ppi_ctrl #(
    parameter logic [7:0] RESET_CTRL = 8'h9B
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic       a1,
    input  logic       a0,
    input  logic [7:0] D,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] pa_in,
    input  logic [7:0] pb_in,
    input  logic [7:0] pc_in,
    output logic [7:0] pa_out,
    output logic [7:0] pb_out,
    output logic [7:0] pc_out,
    output logic       pa_oe,
    output logic       pb_oe,
    output logic [7:0] pc_oe
);

    typedef enum logic [1:0] {
        SEL_PA   = 2'b00,
        SEL_PB   = 2'b01,
        SEL_PC   = 2'b10,
        SEL_CTRL = 2'b11
    } sel_e;

    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] pa_latch_q, pa_latch_d;
    logic [7:0] pb_latch_q, pb_latch_d;
    logic [7:0] pc_latch_q, pc_latch_d;
    logic [7:0] stb_latch_q, stb_latch_d;
    logic       inte_a_q, inte_a_d;
    logic       intr_q, intr_d;
    logic       ibf_q, ibf_d;
    logic       obf_n_q, obf_n_d;
    logic       wr_q, rd_q, stb_q, ack_q;

    sel_e sel;
    logic grp_a_m1, pa_is_in, pb_is_in, pcu_is_in, pcl_is_in;
    logic m1_in, m1_out;
    logic stb_n, ack_n;
    logic stb_fall, stb_rise, ack_fall, ack_rise;
    logic bus_wr, pa_rd_fall, pa_rd_end;

    assign sel       = sel_e'({a1, a0});
    assign grp_a_m1  = |ctrl_q[6:5];
    assign pa_is_in  = ctrl_q[4];
    assign pcu_is_in = ctrl_q[3];
    assign pb_is_in  = ctrl_q[1];
    assign pcl_is_in = ctrl_q[0];
    assign m1_in     = grp_a_m1 & pa_is_in;
    assign m1_out    = grp_a_m1 & ~pa_is_in;

    // STB_n lives on PC4 and ACK_n on PC6; both are active low.
    assign stb_n    = pc_in[4];
    assign ack_n    = pc_in[6];
    assign stb_fall = stb_q & ~stb_n;
    assign stb_rise = ~stb_q & stb_n;
    assign ack_fall = ack_q & ~ack_n;
    assign ack_rise = ~ack_q & ack_n;

    assign bus_wr     = ~cs & ~wr & wr_q;
    assign pa_rd_fall = ~cs & ~rd & wr & rd_q & (sel == SEL_PA);
    assign pa_rd_end  = ~cs & rd & ~rd_q & (sel == SEL_PA);

    assign pa_out = pa_latch_q;
    assign pb_out = pb_latch_q;
    assign pa_oe  = ~pa_is_in;
    assign pb_oe  = ~pb_is_in;

    // Port C pin view: direction bits first, then the handshake bits take over.
    always_comb begin
        pc_oe  = {{4{~pcu_is_in}}, {4{~pcl_is_in}}};
        pc_out = pc_latch_q;
        if (m1_in) begin
            pc_oe[4]  = 1'b0;
            pc_oe[5]  = 1'b1;
            pc_oe[3]  = 1'b1;
            pc_out[5] = ibf_q;
            pc_out[3] = intr_q;
        end
        if (m1_out) begin
            pc_oe[7]  = 1'b1;
            pc_oe[6]  = 1'b0;
            pc_oe[3]  = 1'b1;
            pc_out[7] = obf_n_q;
            pc_out[3] = intr_q;
        end
    end

    // CPU read data; a concurrent write strobe suppresses the read.
    always_comb begin
        d_oe  = ~cs & ~rd & wr;
        d_out = 8'h00;
        if (d_oe) begin
            case (sel)
                SEL_PA:   d_out = m1_in ? stb_latch_q : (pa_is_in ? pa_in : pa_latch_q);
                SEL_PB:   d_out = pb_is_in ? pb_in : pb_latch_q;
                SEL_PC:   d_out = (pc_oe & pc_out) | (~pc_oe & pc_in);
                SEL_CTRL: d_out = ctrl_q;
                default:  d_out = 8'h00;
            endcase
        end
    end

    // Next state: handshake edges first, bus writes afterwards so they win.
    always_comb begin
        ctrl_d      = ctrl_q;
        pa_latch_d  = pa_latch_q;
        pb_latch_d  = pb_latch_q;
        pc_latch_d  = pc_latch_q;
        stb_latch_d = stb_latch_q;
        inte_a_d    = inte_a_q;
        intr_d      = intr_q;
        ibf_d       = ibf_q;
        obf_n_d     = obf_n_q;

        if (m1_in) begin
            // A strobe in the same cycle as the read end keeps IBF set.
            if (stb_fall) begin
                stb_latch_d = pa_in;
                ibf_d       = 1'b1;
            end else if (pa_rd_end) begin
                ibf_d = 1'b0;
            end
            if (stb_rise && inte_a_q) intr_d = 1'b1;
            if (pa_rd_fall)           intr_d = 1'b0;
        end

        if (m1_out) begin
            if (ack_fall)             obf_n_d = 1'b1;
            if (ack_rise && inte_a_q) intr_d  = 1'b1;
        end

        if (bus_wr) begin
            case (sel)
                SEL_PA: begin
                    pa_latch_d = D;
                    if (m1_out) begin
                        obf_n_d = 1'b0;
                        intr_d  = 1'b0;
                    end
                end
                SEL_PB: pb_latch_d = D;
                SEL_PC: pc_latch_d = D;
                SEL_CTRL: begin
                    if (D[7]) begin
                        ctrl_d     = D;
                        pa_latch_d = 8'h00;
                        pb_latch_d = 8'h00;
                        pc_latch_d = 8'h00;
                        inte_a_d   = 1'b0;
                        intr_d     = 1'b0;
                        ibf_d      = 1'b0;
                        obf_n_d    = 1'b1;
                    end else if (m1_in && (D[3:1] == 3'd4)) begin
                        inte_a_d = D[0];
                    end else if (m1_out && (D[3:1] == 3'd6)) begin
                        inte_a_d = D[0];
                    end else begin
                        pc_latch_d[D[3:1]] = D[0];
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; edge registers reset high so reset release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= RESET_CTRL;
            pa_latch_q  <= 8'h00;
            pb_latch_q  <= 8'h00;
            pc_latch_q  <= 8'h00;
            stb_latch_q <= 8'h00;
            inte_a_q    <= 1'b0;
            intr_q      <= 1'b0;
            ibf_q       <= 1'b0;
            obf_n_q     <= 1'b1;
            wr_q        <= 1'b1;
            rd_q        <= 1'b1;
            stb_q       <= 1'b1;
            ack_q       <= 1'b1;
        end else begin
            ctrl_q      <= ctrl_d;
            pa_latch_q  <= pa_latch_d;
            pb_latch_q  <= pb_latch_d;
            pc_latch_q  <= pc_latch_d;
            stb_latch_q <= stb_latch_d;
            inte_a_q    <= inte_a_d;
            intr_q      <= intr_d;
            ibf_q       <= ibf_d;
            obf_n_q     <= obf_n_d;
            wr_q        <= wr;
            rd_q        <= rd;
            stb_q       <= stb_n;
            ack_q       <= ack_n;
        end
    end

endmodule

// File: tb/tb_ppi_ctrl.sv
// Directed testbench for ppi_ctrl: bus decode, BSR, Mode 0 and group A Mode 1.
module tb_ppi_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b1, rd = 1'b1, wr = 1'b1, a1 = 1'b0, a0 = 1'b0;
    logic [7:0] D = 8'h00;
    logic [7:0] pa_in = 8'h00, pb_in = 8'h00, pc_in = 8'hFF;
    logic [7:0] d_out, pa_out, pb_out, pc_out, pc_oe;
    logic       d_oe, pa_oe, pb_oe;

    int checks = 0;
    int errors = 0;

    ppi_ctrl #(.RESET_CTRL(8'h9B)) dut (
        .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .a1(a1), .a0(a0),
        .D(D), .d_out(d_out), .d_oe(d_oe),
        .pa_in(pa_in), .pb_in(pb_in), .pc_in(pc_in),
        .pa_out(pa_out), .pb_out(pb_out), .pc_out(pc_out),
        .pa_oe(pa_oe), .pb_oe(pb_oe), .pc_oe(pc_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        cs = 1'b0; wr = 1'b0; {a1, a0} = addr; D = data;
        tick();
        cs = 1'b1; wr = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        pa_in = 8'h11;
        cs = 1'b0; rd = 1'b0; {a1, a0} = 2'b11;
        #1;
        checks++; if (d_out !== 8'h9B) begin errors++; $display("FAIL reset_ctrl_read: got %h want 9b", d_out); end
        checks++; if (d_oe !== 1'b1) begin errors++; $display("FAIL reset_d_oe: got %b want 1", d_oe); end
        {a1, a0} = 2'b00;
        #1;
        checks++; if (d_out !== 8'h11) begin errors++; $display("FAIL reset_pa_pin_read: got %h want 11", d_out); end
        cs = 1'b1; rd = 1'b1;
        tick();
        checks++; if ({pa_oe, pb_oe, pc_oe} !== 10'b0) begin errors++; $display("FAIL reset_oe: got %b%b %h want 00 00", pa_oe, pb_oe, pc_oe); end
        checks++; if (d_oe !== 1'b0) begin errors++; $display("FAIL idle_d_oe: got %b want 0", d_oe); end
    endtask

    task automatic test_mode0();
        bus_write(2'b11, 8'h80);
        cs = 1'b0; wr = 1'b0; {a1, a0} = 2'b00; D = 8'h5A;
        #1;
        checks++; if (pa_out !== 8'h00) begin errors++; $display("FAIL pa_before_edge: got %h want 00", pa_out); end
        tick();
        checks++; if (pa_out !== 8'h5A) begin errors++; $display("FAIL pa_after_edge: got %h want 5a", pa_out); end
        cs = 1'b1; wr = 1'b1;
        tick();
        bus_write(2'b01, 8'hC3);
        bus_write(2'b10, 8'h0F);
        checks++; if ({pa_out, pb_out, pc_out} !== 24'h5AC30F) begin errors++; $display("FAIL m0_latches: got %h%h%h want 5ac30f", pa_out, pb_out, pc_out); end
        checks++; if ({pa_oe, pb_oe, pc_oe} !== 10'b11_1111_1111) begin errors++; $display("FAIL m0_oe: got %b%b %h want 11 ff", pa_oe, pb_oe, pc_oe); end
        cs = 1'b0; rd = 1'b0; {a1, a0} = 2'b00;
        #1;
        checks++; if (d_out !== 8'h5A) begin errors++; $display("FAIL m0_pa_out_read: got %h want 5a", d_out); end
        cs = 1'b1; rd = 1'b1;
        tick();
        // PC upper input, lower output: per-bit read merge
        bus_write(2'b11, 8'h88);
        checks++; if ({pa_out, pc_out} !== 16'h0000) begin errors++; $display("FAIL m0_mode_clear: got %h%h want 0000", pa_out, pc_out); end
        checks++; if (pc_oe !== 8'h0F) begin errors++; $display("FAIL m0_pc_oe_split: got %h want 0f", pc_oe); end
        bus_write(2'b10, 8'h3C);
        pc_in = 8'hF0;
        cs = 1'b0; rd = 1'b0; {a1, a0} = 2'b10;
        #1;
        checks++; if (d_out !== 8'hFC) begin errors++; $display("FAIL m0_pc_merge_read: got %h want fc", d_out); end
        cs = 1'b1; rd = 1'b1; pc_in = 8'hFF;
        tick();
    endtask

    task automatic test_bsr();
        bus_write(2'b11, 8'h80);
        bus_write(2'b10, 8'hA5);
        bus_write(2'b11, 8'h07);
        checks++; if (pc_out !== 8'hAD) begin errors++; $display("FAIL bsr_set3: got %h want ad", pc_out); end
        bus_write(2'b11, 8'h06);
        checks++; if (pc_out !== 8'hA5) begin errors++; $display("FAIL bsr_clr3: got %h want a5", pc_out); end
        bus_write(2'b11, 8'h0E);
        checks++; if (pc_out !== 8'h25) begin errors++; $display("FAIL bsr_clr7: got %h want 25", pc_out); end
        bus_write(2'b00, 8'h12);
        bus_write(2'b11, 8'h80);
        checks++; if ({pa_out, pb_out, pc_out} !== 24'h0) begin errors++; $display("FAIL bsr_mode_clear: got %h%h%h want 000000", pa_out, pb_out, pc_out); end
    endtask

    task automatic test_mode1_in();
        bus_write(2'b11, 8'hB0);
        checks++; if ({pa_oe, pc_oe} !== 9'h0EF) begin errors++; $display("FAIL m1i_oe: got %b %h want 0 ef", pa_oe, pc_oe); end
        bus_write(2'b11, 8'h09);
        pa_in = 8'hA5; pc_in = 8'hEF;
        tick();
        checks++; if ({pc_out[5], pc_out[3]} !== 2'b10) begin errors++; $display("FAIL m1i_stb_fall: got ibf/intr %b want 10", {pc_out[5], pc_out[3]}); end
        pa_in = 8'h00;
        tick();
        pc_in = 8'hFF;
        tick();
        checks++; if ({pc_out[5], pc_out[3]} !== 2'b11) begin errors++; $display("FAIL m1i_stb_rise: got ibf/intr %b want 11", {pc_out[5], pc_out[3]}); end
        cs = 1'b0; rd = 1'b0; {a1, a0} = 2'b00;
        #1;
        checks++; if (d_out !== 8'hA5) begin errors++; $display("FAIL m1i_strobe_read: got %h want a5", d_out); end
        tick();
        checks++; if ({pc_out[5], pc_out[3]} !== 2'b10) begin errors++; $display("FAIL m1i_rd_fall: got ibf/intr %b want 10", {pc_out[5], pc_out[3]}); end
        rd = 1'b1;
        tick();
        checks++; if (pc_out[5] !== 1'b0) begin errors++; $display("FAIL m1i_rd_end: got ibf %b want 0", pc_out[5]); end
        // strobe fall coincident with read end: strobe wins
        rd = 1'b0;
        tick();
        rd = 1'b1; pc_in = 8'hEF;
        tick();
        checks++; if (pc_out[5] !== 1'b1) begin errors++; $display("FAIL m1i_stb_vs_rd_end: got ibf %b want 1", pc_out[5]); end
        cs = 1'b1; pc_in = 8'hFF;
        tick();
    endtask

    task automatic test_mode1_out();
        bus_write(2'b11, 8'hA0);
        checks++; if ({pa_oe, pc_oe} !== 9'h1BF) begin errors++; $display("FAIL m1o_oe: got %b %h want 1 bf", pa_oe, pc_oe); end
        checks++; if ({pc_out[7], pc_out[3]} !== 2'b10) begin errors++; $display("FAIL m1o_idle: got obf/intr %b want 10", {pc_out[7], pc_out[3]}); end
        bus_write(2'b11, 8'h0D);
        bus_write(2'b00, 8'h3C);
        checks++; if ({pa_out, pc_out[7]} !== 9'h078) begin errors++; $display("FAIL m1o_write: got %h %b want 3c 0", pa_out, pc_out[7]); end
        bus_write(2'b11, 8'h0F);
        checks++; if (pc_out[7] !== 1'b0) begin errors++; $display("FAIL m1o_bsr_owned_bit: got %b want 0", pc_out[7]); end
        pc_in = 8'hBF;
        tick();
        checks++; if ({pc_out[7], pc_out[3]} !== 2'b10) begin errors++; $display("FAIL m1o_ack_fall: got obf/intr %b want 10", {pc_out[7], pc_out[3]}); end
        pc_in = 8'hFF;
        tick();
        checks++; if (pc_out[3] !== 1'b1) begin errors++; $display("FAIL m1o_ack_rise: got intr %b want 1", pc_out[3]); end
        bus_write(2'b00, 8'h77);
        checks++; if ({pa_out, pc_out[7], pc_out[3]} !== {8'h77, 2'b00}) begin errors++; $display("FAIL m1o_rewrite: got %h %b%b want 77 00", pa_out, pc_out[7], pc_out[3]); end
        pc_in = 8'hBF;
        tick();
        pc_in = 8'hFF;
        tick();
        // write coincident with ACK fall: write wins
        cs = 1'b0; wr = 1'b0; {a1, a0} = 2'b00; D = 8'h11; pc_in = 8'hBF;
        tick();
        checks++; if ({pa_out, pc_out[7], pc_out[3]} !== {8'h11, 2'b00}) begin errors++; $display("FAIL m1o_write_vs_ack: got %h %b%b want 11 00", pa_out, pc_out[7], pc_out[3]); end
        cs = 1'b1; wr = 1'b1; pc_in = 8'hFF;
        tick();
    endtask

    task automatic test_back_to_back();
        bus_write(2'b11, 8'h80);
        cs = 1'b0; rd = 1'b0; wr = 1'b0; {a1, a0} = 2'b01; D = 8'h66;
        #1;
        checks++; if (d_oe !== 1'b0) begin errors++; $display("FAIL rdwr_d_oe: got %b want 0", d_oe); end
        tick();
        checks++; if (pb_out !== 8'h66) begin errors++; $display("FAIL rdwr_write: got %h want 66", pb_out); end
        cs = 1'b1; rd = 1'b1; wr = 1'b1;
        tick();
        wr = 1'b0; D = 8'h99;
        tick();
        wr = 1'b1; rd = 1'b0;
        tick();
        checks++; if ({pb_out, d_oe} !== {8'h66, 1'b0}) begin errors++; $display("FAIL cs_block: got %h %b want 66 0", pb_out, d_oe); end
        rd = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        bus_write(2'b11, 8'hB0);
        bus_write(2'b11, 8'h09);
        pc_in = 8'hEF;
        tick();
        pc_in = 8'hFF;
        tick();
        checks++; if ({pc_out[5], pc_out[3]} !== 2'b11) begin errors++; $display("FAIL mid_setup: got ibf/intr %b want 11", {pc_out[5], pc_out[3]}); end
        reset = 1'b1; pc_in = 8'hEF;
        tick();
        reset = 1'b0;
        checks++; if ({pc_out, pc_oe, pa_oe} !== 17'h0) begin errors++; $display("FAIL mid_reset_pins: got %h %h %b want 00 00 0", pc_out, pc_oe, pa_oe); end
        cs = 1'b0; rd = 1'b0; {a1, a0} = 2'b11;
        #1;
        checks++; if (d_out !== 8'h9B) begin errors++; $display("FAIL mid_reset_ctrl: got %h want 9b", d_out); end
        cs = 1'b1; rd = 1'b1;
        tick(); tick();
        bus_write(2'b11, 8'hB0);
        checks++; if ({pc_out[5], pc_out[3]} !== 2'b00) begin errors++; $display("FAIL mid_no_false_stb: got ibf/intr %b want 00", {pc_out[5], pc_out[3]}); end
        cs = 1'b0; rd = 1'b0; {a1, a0} = 2'b00;
        #1;
        checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL mid_strobe_latch_cleared: got %h want 00", d_out); end
        cs = 1'b1; rd = 1'b1; pc_in = 8'hFF;
        tick();
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_bsr();
        test_mode1_in();
        test_mode1_out();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppi_ctrl.md
Name: ppi_ctrl

Overview:
- Clocked 8255-style bus controller for the PPI. It decodes CPU reads and writes on cs/a1/a0/rd/wr/D into port A/B/C latches, a control (mode) word, and bit set/reset (BSR) operations on port C.
- It sequences Mode 0 (basic I/O) for both groups and Mode 1 (strobed handshake) for group A.
- Pin-level inputs and outputs are split (in / out / oe), so the top-level PPI builds its PA/PB/PC inouts from them.

Parameters:
- RESET_CTRL, 8'h9B, control word loaded at reset (Mode 0, all ports input).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  chip select, active low.
- rd  in  1  read strobe, active low.
- wr  in  1  write strobe, active low.
- a1, a0  in  1 each  register select: 00=PA, 01=PB, 10=PC, 11=control.
- D  in  8  CPU write data.
- d_out  out  8  CPU read data.
- d_oe  out  1  d_out valid/drive enable.
- pa_in, pb_in, pc_in  in  8 each  pin input values.
- pa_out, pb_out, pc_out  out  8 each  pin output values.
- pa_oe, pb_oe  out  1 each  port drive enable.
- pc_oe  out  8  per-bit drive enable for port C.

Behaviour:
- All inputs are synchronous to clk; synchronizers sit outside this block.
- Edge detection: wr_q, rd_q, stb_q and ack_q are registered copies of the previous-cycle values.
- **Write event:** the cycle with cs=0, wr=0 and wr_q=1. D, a1 and a0 are taken from that cycle, the register updates at that clk edge, and the effect is visible the next cycle.
- **Read:** while cs=0, rd=0 and wr=1, d_oe=1 and d_out is combinational from the selected source:
  - PA/PB: the pin input if the port is an input, else its latch. PA in Mode 1 input returns the strobe latch.
  - PC: per bit, the input pin if that bit is an input, else latch/handshake value.
  - Control: returns the control register.
- **Read end event:** the cycle with rd=1 and rd_q=0 while cs=0.
- **Control word (a1a0=11, D7=1):**
  - D6:5 = group A mode. 00 = Mode 0; any other value = Mode 1.
  - D4 = PA direction (1 = input).
  - D3 = PC[7:4] direction.
  - D2 = group B mode; it is stored but always operates as Mode 0.
  - D1 = PB direction.
  - D0 = PC[3:0] direction.
  - Writing a mode word clears all output latches, INTE_A, INTR, IBF and forces OBF_n=1.
- **BSR (a1a0=11, D7=0):** PC latch bit D3:1 is set to D0.
  - In Mode 1 input, BSR to bit 4 writes INTE_A instead of the pin latch.
  - In Mode 1 output, BSR to bit 6 writes INTE_A.
  - BSR to other handshake-owned bits updates the latch only; the pin stays handshake-driven.
- **Mode 0:** pX_oe = direction==output. pc_oe[7:4] and [3:0] follow D3 and D0.
- **Mode 1, PA input:**
  - PC4 = STB_n (input), PC5 = IBF (output), PC3 = INTR (output). pa_oe=0.
  - STB_n falling edge: capture pa_in into strobe latch, IBF=1.
  - STB_n rising edge: INTR=1 if INTE_A=1.
  - rd falling edge on PA: INTR=0.
  - PA read end event: IBF=0.
- **Mode 1, PA output:**
  - PC7 = OBF_n (output), PC6 = ACK_n (input), PC3 = INTR (output). pa_oe=1.
  - Write to PA: latch D, OBF_n=0, INTR=0.
  - ACK_n falling edge: OBF_n=1.
  - ACK_n rising edge: INTR=1 if INTE_A=1.
- In Mode 1, the remaining PC bits (PC[2:0]; PC6/7 in input mode; PC4/5 in output mode) follow the D3/D0 direction bits as in Mode 0.
- **Simultaneous events:**
  - cs=0 with rd=0 and wr=0: write proceeds, d_oe=0.
  - Write event to PA in the same cycle as an ACK_n falling edge: the write wins (OBF_n=0).
  - STB_n falling edge in the same cycle as a PA read end event: IBF=1 (the strobe wins).
- cs=1 blocks all bus events. Handshake edges are still processed.
- **Reset (any cycle, including mid-handshake):**
  - ctrl=RESET_CTRL; all latches=0; INTE_A=0, INTR=0, IBF=0, OBF_n=1.
  - Edge registers = 1 (idle-high), so no false edge is taken on reset release.
  - d_oe=0, all oe=0.

Test Plan:
- Reset, then read control (cs=0, rd=0, a1a0=11) -> d_out=8'h9B, d_oe=1; pa_oe=pb_oe=0, pc_oe=8'h00.
- Write 8'h80, then write PA=8'h5A, PB=8'hC3, PC=8'h0F -> next cycle pa_out=5A, pb_out=C3, pc_out=0F, all oe=1.
- Mode 0 all-output, BSR writes 8'h07 then 8'h06 -> pc_out[3] goes 1 then 0, other bits unchanged; mode rewrite 8'h80 clears latches to 0.
- Mode 1 PA input (8'hB0), BSR 8'h09 (INTE_A=1); pa_in=8'hA5, pulse PC4 low 2 cycles -> IBF=1 after the fall, INTR=1 after the rise. PA read returns A5 with INTR=0 on the rd fall and IBF=0 one cycle after the rd rise.
- Mode 1 PA output (8'hA0), BSR 8'h0D; write PA=8'h3C -> OBF_n=0, pa_out=3C. ACK_n low -> OBF_n=1; ACK_n high -> INTR=1. Next PA write clears INTR.
- Assert reset mid-handshake (IBF=1, INTR=1) -> next cycle IBF=0, INTR=0, ctrl=9B. Release with PC4 held low -> no IBF set.
